uart_rx_fifo: RTL

Second-generation APB-side UART receiver. Generalises the fixed 8/10-bit receiver with a runtime-selectable word length of 5 to DATA_MAX bits, optional parity, and a glitch-rejecting start detector. Received words are buffered in an on-chip FIFO, and framing, parity and overrun errors are reported as sticky flags. It sits behind the APB slave decode and is driven by the register block through sel, rx_en, mode and baud.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/rx_fifo.sv | 66 ++++++
 rtl/uart_rx_fifo.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, limits and helpers for the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM states, fixed 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Default maximum data bits per frame
  localparam int DATA_MAX_DEFAULT = 10;

  // Word-length register clamp: mode holds (data bits - 1)
  localparam int MODE_MIN = 4;
  localparam int MODE_MAX = DATA_MAX_DEFAULT - 1;

  // Smallest usable baud divisor (clocks per bit)
  localparam int BAUD_MIN = 2;

  // XOR reduction of a zero-extended data word
  function automatic logic parity16(input logic [15:0] bits);
    return ^bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_fifo
// Description : Synchronous show-ahead FIFO with occupancy count. Head word
//               is presented combinationally; reads 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_pop;
  logic               w_push;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it
  assign w_pop  = rd_en & (r_count != '0);
  assign w_push = wr_en & ((r_count != c_depth) | w_pop);

  assign empty   = (r_count == '0);
  assign full    = (r_count == c_depth);
  assign count   = r_count;
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array, write port only
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks net occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receiver with runtime word length (5..DATA_MAX bits),
//               optional parity, false-start rejection, RX FIFO and sticky
//               frame/parity/overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_MAX    = DATA_MAX_DEFAULT,
  parameter int FIFO_DEPTH  = 8,
  parameter int BAUD_W      = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          sel,
  input  logic                          rx_en,
  input  logic [3:0]                    mode,
  input  logic                          par_en,
  input  logic                          par_odd,
  input  logic [BAUD_W-1:0]             baud,
  input  logic                          rx_in,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [31:0]                   rx_data,
  output logic                          rx_valid,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int                c_idx_w    = $clog2(DATA_MAX);
  localparam logic [3:0]        c_mode_min = 4'(MODE_MIN);
  localparam logic [3:0]        c_mode_max = 4'(DATA_MAX - 1);
  localparam logic [BAUD_W-1:0] c_baud_min = BAUD_W'(BAUD_MIN);

  rx_state_t             r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_sync_prev;
  logic [BAUD_W-1:0]     r_timer;
  logic [3:0]            r_bit_cnt;
  logic [DATA_MAX-1:0]   r_shift;
  logic [3:0]            r_mode;
  logic                  r_par_en;
  logic                  r_par_odd;
  logic [BAUD_W-1:0]     r_baud;

  logic [3:0]            w_mode_clamp;
  logic [BAUD_W-1:0]     w_baud_clamp;
  logic                  w_line;
  logic                  w_fall;
  logic                  w_tick;
  logic                  w_active;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_par_set;
  logic                  w_frame_set;
  logic                  w_ovr_set;
  logic                  w_fifo_empty;
  logic [DATA_MAX-1:0]   w_fifo_data;

  // Clamp the requested word length and divisor into the supported range
  always_comb begin
    w_mode_clamp = mode;
    if (mode < c_mode_min)      w_mode_clamp = c_mode_min;
    else if (mode > c_mode_max) w_mode_clamp = c_mode_max;
  end
  assign w_baud_clamp = (baud < c_baud_min) ? c_baud_min : baud;

  // Latch configuration only between frames so a frame never sees a mid-stream change
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode    <= c_mode_min;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_baud    <= c_baud_min;
    end else if (sel && (r_state == ST_IDLE)) begin
      r_mode    <= w_mode_clamp;
      r_par_en  <= par_en;
      r_par_odd <= par_odd;
      r_baud    <= w_baud_clamp;
    end
  end

  // Metastability synchroniser plus one delayed copy for edge detection; idles high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync      <= '1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], rx_in};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_line   = r_sync[SYNC_STAGES-1];
  assign w_fall   = r_sync_prev & ~w_line;
  assign w_tick   = (r_timer == BAUD_W'(1));
  assign w_active = rx_en & (r_state != ST_IDLE);

  // Sampling events; the stop sample is also the push point
  assign w_push      = w_active & (r_state == ST_STOP) & w_tick;
  assign w_frame_set = w_push & ~w_line;
  assign w_par_set   = w_active & (r_state == ST_PARITY) & w_tick &
                       ((parity16(16'(r_shift)) ^ w_line) != r_par_odd);
  assign w_pop       = rd_en & ~w_fifo_empty;
  assign w_ovr_set   = w_push & fifo_full & ~w_pop;

  // Frame FSM: half-bit wait to centre on the start bit, then whole-bit sampling
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if ((r_state != ST_IDLE) && !rx_en) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall && rx_en) begin
            r_state <= ST_START;
            r_timer <= r_baud >> 1;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (!w_line) begin
              r_state   <= ST_DATA;
              r_timer   <= r_baud;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift[r_bit_cnt[c_idx_w-1:0]] <= w_line;
            r_timer <= r_baud;
            if (r_bit_cnt == r_mode) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_timer <= r_baud;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) r_state <= ST_IDLE;
          else        r_timer <= r_timer - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new fault wins over a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_frame_set)  frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (w_par_set)    parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (w_ovr_set)    overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  rx_fifo #(
    .WIDTH (DATA_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (w_push),
    .wr_data (r_shift),
    .rd_en   (rd_en),
    .rd_data (w_fifo_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (w_fifo_empty)
  );

  assign rx_valid = ~w_fifo_empty;
  assign rx_data  = 32'(w_fifo_data);

endmodule
`default_nettype wire
